// File: rtl/reduce_vector_engine_if.sv
// Command/result bundle between the host command decoder and the vector
// reduce engine. The decoder is the master: it drives the operands and
// the command, and receives the scalar result and status.
interface reduce_vector_engine_if #(
    parameter int BITS  = 8,
    parameter int N     = 8,
    parameter int LEN_W = 8
);
    logic                   i_en;
    logic                   i_start;
    logic [N-1:0][BITS-1:0] i_in;
    logic [LEN_W-1:0]       i_in_len;
    logic [2:0]             i_sel;
    logic                   i_signed_mode;
    logic [BITS-1:0]        o_out;
    logic                   o_done;
    logic                   o_busy;
    logic                   o_overflow;

    modport master (
        output i_en, i_start, i_in, i_in_len, i_sel, i_signed_mode,
        input  o_out, o_done, o_busy, o_overflow
    );

    modport slave (
        input  i_en, i_start, i_in, i_in_len, i_sel, i_signed_mode,
        output o_out, o_done, o_busy, o_overflow
    );
endinterface

// File: rtl/reduce_vector_engine.sv
// Multi-lane vector reduction engine. A start snapshots the operand vector
// and command, then LANES elements per enabled cycle are folded into a
// wide accumulator with the selected operator. The scalar result (wrapped
// or saturated for the sum modes) is held with done until the next start.
module reduce_vector_engine #(
    parameter int BITS  = 8,
    parameter int N     = 8,
    parameter int LANES = 2,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reduce_vector_engine_if.slave bus
);

    // The accumulator carries clog2(N)+1 extra bits so an exact sum of up
    // to N elements, signed or unsigned, never wraps internally.
    localparam int CLOG_N = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W  = BITS + CLOG_N + 1;
    localparam int LEN_IW = CLOG_N;
    localparam int IDX_W  = $clog2(N + LANES) + 1;

    // Result range limits expressed in accumulator width for the overflow
    // test and the saturating clamp.
    localparam logic signed [ACC_W-1:0] LIM_SMAX =
        {{(ACC_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LIM_SMIN =
        {{(ACC_W-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] LIM_UMAX =
        {{(ACC_W-BITS){1'b0}}, {BITS{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_SUM    = 3'b000,
        OP_MAX    = 3'b001,
        OP_MIN    = 3'b010,
        OP_AND    = 3'b011,
        OP_OR     = 3'b100,
        OP_XOR    = 3'b101,
        OP_SAT    = 3'b110,
        OP_SUMALT = 3'b111
    } op_e;

    state_e                     r_state;
    logic [N-1:0][BITS-1:0]     r_in;
    op_e                        r_sel;
    logic                       r_signed;
    logic [LEN_IW-1:0]          r_len;
    logic [IDX_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic [BITS-1:0]            r_out;
    logic                       r_done;
    logic                       r_busy;
    logic                       r_overflow;

    logic [LEN_IW-1:0]          w_start_len;
    logic signed [ACC_W-1:0]    w_start_acc;
    logic [IDX_W-1:0]           w_len_ext;
    logic [IDX_W-1:0]           w_pos;
    logic signed [ACC_W-1:0]    w_fold_acc;
    logic                       w_last;
    logic signed [ACC_W-1:0]    w_next_acc;
    op_e                        w_fin_sel;
    logic                       w_fin_signed;
    logic                       w_is_sum;
    logic                       w_range_bad;
    logic [BITS-1:0]            w_fin_out;
    logic                       w_fin_ovf;

    // Widen an element into the accumulator domain. With every element
    // extended per signed_mode, a single signed compare serves both the
    // signed and the unsigned MIN/MAX, and logic ops stay correct in the
    // low BITS.
    function automatic logic signed [ACC_W-1:0] extend(
        input logic [BITS-1:0] v,
        input logic            s
    );
        return {{(ACC_W-BITS){s & v[BITS-1]}}, v};
    endfunction

    // One reduction step of the selected operator.
    function automatic logic signed [ACC_W-1:0] combine(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W-1:0] e,
        input op_e                     op
    );
        case (op)
            OP_MAX:  return (e > acc) ? e : acc;
            OP_MIN:  return (e < acc) ? e : acc;
            OP_AND:  return acc & e;
            OP_OR:   return acc | e;
            OP_XOR:  return acc ^ e;
            default: return acc + e;
        endcase
    endfunction

    // Clamp the requested last index to the vector capacity and seed the
    // accumulator with element 0.
    always_comb begin
        if (int'(bus.i_in_len) > N - 1) begin
            w_start_len = LEN_IW'(N - 1);
        end else begin
            w_start_len = LEN_IW'(bus.i_in_len);
        end
        w_start_acc = extend(bus.i_in[0], bus.i_signed_mode);
    end

    // Fold up to LANES consecutive elements starting at idx, skipping any
    // lane that falls past the last valid element.
    always_comb begin
        w_len_ext  = {{(IDX_W-LEN_IW){1'b0}}, r_len};
        w_fold_acc = r_acc;
        w_pos      = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pos = r_idx + IDX_W'(l);
            if ((w_pos <= w_len_ext) && (w_pos < IDX_W'(N))) begin
                w_fold_acc = combine(w_fold_acc,
                                     extend(r_in[w_pos[LEN_IW-1:0]], r_signed),
                                     r_sel);
            end
        end
        w_last = (r_idx + IDX_W'(LANES)) > w_len_ext;
    end

    // Final result formatting; the same logic serves a zero-length start
    // (straight from the inputs) and the last RUN step (from the snapshot).
    always_comb begin
        if (r_state == S_RUN) begin
            w_next_acc   = w_fold_acc;
            w_fin_sel    = r_sel;
            w_fin_signed = r_signed;
        end else begin
            w_next_acc   = w_start_acc;
            w_fin_sel    = op_e'(bus.i_sel);
            w_fin_signed = bus.i_signed_mode;
        end
        w_is_sum = (w_fin_sel == OP_SUM) || (w_fin_sel == OP_SAT) ||
                   (w_fin_sel == OP_SUMALT);
        if (w_fin_signed) begin
            w_range_bad = (w_next_acc > LIM_SMAX) || (w_next_acc < LIM_SMIN);
        end else begin
            w_range_bad = (w_next_acc > LIM_UMAX);
        end
        w_fin_ovf = w_is_sum && w_range_bad;
        w_fin_out = w_next_acc[BITS-1:0];
        if ((w_fin_sel == OP_SAT) && w_range_bad) begin
            if (!w_fin_signed) begin
                w_fin_out = '1;
            end else if (w_next_acc[ACC_W-1]) begin
                w_fin_out = LIM_SMIN[BITS-1:0];
            end else begin
                w_fin_out = LIM_SMAX[BITS-1:0];
            end
        end
    end

    // Control FSM with registered status and result; en low freezes it all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in       <= '0;
            r_sel      <= OP_SUM;
            r_signed   <= 1'b0;
            r_len      <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_out      <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (bus.i_en) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        r_in     <= bus.i_in;
                        r_sel    <= op_e'(bus.i_sel);
                        r_signed <= bus.i_signed_mode;
                        r_len    <= w_start_len;
                        r_acc    <= w_start_acc;
                        r_idx    <= IDX_W'(1);
                        if (w_start_len == '0) begin
                            r_state    <= S_DONE;
                            r_out      <= w_fin_out;
                            r_overflow <= w_fin_ovf;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state    <= S_RUN;
                            r_overflow <= 1'b0;
                            r_done     <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_fold_acc;
                    r_idx <= r_idx + IDX_W'(LANES);
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_out      <= w_fin_out;
                        r_overflow <= w_fin_ovf;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_out      = r_out;
    assign bus.o_done     = r_done;
    assign bus.o_busy     = r_busy;
    assign bus.o_overflow = r_overflow;

endmodule

// File: doc/reduce_vector_engine.md
# reduce_vector_engine

Multi-lane, multi-mode vector reduction engine; the parametrised successor to the single-lane reduce ALU in the vector accelerator datapath. On `start` it snapshots up to N operands, folds LANES elements per cycle with the selected operator (sum, saturating sum, min, max, and, or, xor), and holds the scalar result with `done` until the next start. It sits behind the host command decoder and feeds the scalar result register.

## Interface
- `BITS`, 8, element and result width
- `N`, 8, maximum vector length (elements)
- `LANES`, 2, elements folded per RUN cycle (1..N)
- `LEN_W`, 8, width of `in_len`

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  clock enable; low freezes all state and outputs
- `start`  in  1  begin reduction (sampled when `en`=1 and not busy)
- `in`  in  N x BITS  operand array; `in[0]` is first element
- `in_len`  in  LEN_W  index of last valid element (element count = `in_len`+1)
- `sel`  in  3  operator: 000 SUM wrap, 001 MAX, 010 MIN, 011 AND, 100 OR, 101 XOR, 110 SUM saturating, 111 same as 000
- `signed_mode`  in  1  1 = two's-complement compare/overflow, 0 = unsigned
- `out`  out  BITS  result
- `done`  out  1  level, high while result valid (DONE state)
- `busy`  out  1  high in RUN
- `overflow`  out  1  SUM modes: exact sum out of BITS range; 0 for other modes

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE; `out`=0, `done`=0, `busy`=0, `overflow`=0.
- Start accepted in IDLE or DONE when `en`=1 and `start`=1. On that edge: snapshot `in`, `sel`, `signed_mode`; `len` = min(`in_len`, N-1); `acc` <= `in[0]` (sign/zero-extended); `idx` <= 1; `done` <= 0; next state RUN, or DONE directly if `len`=0.
- RUN, each enabled edge: fold elements `idx`..min(`idx`+LANES-1, `len`) into `acc`; `idx` += LANES; when `idx`+LANES > `len` -> DONE.
- `start` in RUN ignored (no queueing).
- Accumulator width for SUM = BITS + clog2(N) + 1; sum is exact, no intermediate wrap.
- Entering DONE: `out` = low BITS of `acc` (000/111), or clamped to [min,max] of BITS per `signed_mode` (110); MAX/MIN/logic modes `out` = `acc`. `overflow` set if exact sum outside range (SUM modes only). `done`=1, `busy`=0.
- DONE holds `out`/`done`/`overflow` until a new start is accepted.
- `en`=0: no state, counter, or output changes; `start` not sampled.
- `rst_n` low at any time (incl. mid-RUN): immediate abort, all outputs to reset values, IDLE.
- Operand changes after the start edge do not affect the result.

## Timing
- Start edge = edge 0. `done` visible after edge `R` where `R` = ceil(`len`/LANES) (enabled edges, counting from edge 0). `len`=0 -> `done` after edge 0.
- Example: N=8, LANES=2, `len`=3: RUN at edges 1, 2; `done` high after edge 2.
- `busy` high from after edge 0 until the edge entering DONE; `busy` and `done` never both high.
- Edges with `en`=0 are not counted; latency extends by one per stalled cycle.
- Back-to-back: start accepted in the first DONE cycle; `done` drops after that edge.

## Test plan
- `in[3..0]`=7F,12,40,04, `in_len`=3, `signed_mode`=0: SUM -> `out`=D5, `overflow`=0; MAX -> 7F; MIN -> 04; AND -> 00; OR -> 7F; XOR -> 29; `done` after edge 2 (LANES=2), after edge 3 (LANES=1).
- Same data, `signed_mode`=1: SUM wrap -> `out`=D5, `overflow`=1; SUM saturating -> 7F, `overflow`=1; `in[2]`=80, MIN -> 80, MAX -> 7F.
- `in_len`=0, `in[0]`=5A, any `sel`: `out`=5A, `done` after edge 0; `in_len`=200 (N=8): all 8 elements reduced (clamp), `done` after edge 4 (LANES=2).
- `en` low for 3 cycles mid-RUN, operands changed after start, `start` pulsed while busy: result unchanged vs. unstalled run, `done` 3 cycles later, second start ignored.
- `rst_n` asserted mid-RUN: `out`=0, `done`=0, `busy`=0, `overflow`=0 immediately; next start after release gives correct result.
- Back-to-back starts from DONE with different `sel`: second result correct, `done` low for exactly the RUN cycles between.
